// File: rtl/fazyrv_tgt_ser.sv
// Chunk-serial jump/branch target generator: emits base+off (or base) LSB chunk
// first, BWIDTH bits per shift, for the PC's serial load input.
module fazyrv_tgt_ser #(
   parameter int BWIDTH = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [31:0]       base_i,
   input  logic [31:0]       off_i,
   input  logic              add_i,
   input  logic              clr_lsb_i,
   input  logic              stall_i,
   output logic              busy_o,
   output logic              shift_o,
   output logic [BWIDTH-1:0] dout_o,
   output logic              done_o
);

   localparam int N  = 32 / BWIDTH;
   localparam int CW = $clog2(N);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q, state_d;
   logic [31:0]       base_q, off_q;
   logic              clr_q;
   logic              carry_q;
   logic [CW-1:0]     cnt_q;
   logic [BWIDTH:0]   sum;
   logic              adv;
   logic              last;

   // Operands are shifted down each advance, so the active chunk always sits
   // in the low BWIDTH bits instead of being selected by the counter.
   always_comb begin
      sum     = {1'b0, base_q[BWIDTH-1:0]} + {1'b0, off_q[BWIDTH-1:0]}
              + {{BWIDTH{1'b0}}, carry_q};
      last    = (cnt_q == CW'(N - 1));
      state_d = state_q;
      adv     = 1'b0;
      busy_o  = 1'b0;
      shift_o = 1'b0;
      done_o  = 1'b0;
      dout_o  = '0;
      case (state_q)
         IDLE: begin
            if (start_i) state_d = RUN;
         end
         RUN: begin
            busy_o  = 1'b1;
            adv     = !stall_i;
            shift_o = adv;
            dout_o  = sum[BWIDTH-1:0];
            // LSB clear only masks the output; the carry keeps the true sum.
            if (clr_q && cnt_q == '0) dout_o[0] = 1'b0;
            if (adv && last) begin
               done_o  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         base_q  <= '0;
         off_q   <= '0;
         clr_q   <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE) begin
            if (start_i) begin
               base_q  <= base_i;
               off_q   <= add_i ? off_i : '0;
               clr_q   <= clr_lsb_i;
               carry_q <= 1'b0;
               cnt_q   <= '0;
            end
         end else if (adv) begin
            base_q  <= base_q >> BWIDTH;
            off_q   <= off_q >> BWIDTH;
            carry_q <= sum[BWIDTH];
            cnt_q   <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_fazyrv_tgt_ser.sv
// Bench for fazyrv_tgt_ser: three widths (8, 1, 4) checked every cycle against
// a word-level model, plus directed transfers with literal chunk expectations.
module tb_fazyrv_tgt_ser;

   logic        clk = 1'b0;
   logic        rst, stall, add, clr;
   logic [31:0] base, off;
   logic [2:0]  start;
   logic [2:0]  busy, shift, done;
   logic [7:0]  d8;
   logic [0:0]  d1;
   logic [3:0]  d4;

   int n_chk  = 0;
   int n_fail = 0;
   logic chk_en = 1'b0;

   // capture of the active instance
   int         act = 0;
   logic [7:0] cap[$];
   int         done_cnt, done_idx, busy_cyc;

   // word-level model state per instance (0: BWIDTH 8, 1: BWIDTH 1, 2: BWIDTH 4)
   logic        mbusy[3];
   int          mk[3];
   logic [31:0] mres[3];

   always #5 clk = ~clk;

   fazyrv_tgt_ser #(.BWIDTH(8)) u8 (
      .clk_i(clk), .rst_i(rst), .start_i(start[0]), .base_i(base), .off_i(off),
      .add_i(add), .clr_lsb_i(clr), .stall_i(stall), .busy_o(busy[0]),
      .shift_o(shift[0]), .dout_o(d8), .done_o(done[0]));
   fazyrv_tgt_ser #(.BWIDTH(1)) u1 (
      .clk_i(clk), .rst_i(rst), .start_i(start[1]), .base_i(base), .off_i(off),
      .add_i(add), .clr_lsb_i(clr), .stall_i(stall), .busy_o(busy[1]),
      .shift_o(shift[1]), .dout_o(d1), .done_o(done[1]));
   fazyrv_tgt_ser #(.BWIDTH(4)) u4 (
      .clk_i(clk), .rst_i(rst), .start_i(start[2]), .base_i(base), .off_i(off),
      .add_i(add), .clr_lsb_i(clr), .stall_i(stall), .busy_o(busy[2]),
      .shift_o(shift[2]), .dout_o(d4), .done_o(done[2]));

   function automatic int wid(input int i);
      return (i == 0) ? 8 : ((i == 1) ? 1 : 4);
   endfunction

   function automatic logic [7:0] dout_of(input int i);
      case (i)
         0:       return d8;
         1:       return {7'b0, d1};
         default: return {4'b0, d4};
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
      n_chk++;
      if (act_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act_v, exp_v, $time);
      end
   endtask

   // Model: result word is computed once at acceptance; chunk k is a plain shift.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            mbusy[i] <= 1'b0;
            mk[i]    <= 0;
         end else if (!mbusy[i]) begin
            if (start[i]) begin
               mbusy[i] <= 1'b1;
               mk[i]    <= 0;
               mres[i]  <= (base + (add ? off : 32'd0)) & (clr ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
            end
         end else if (!stall) begin
            if (mk[i] == 32 / wid(i) - 1) mbusy[i] <= 1'b0;
            else                          mk[i]    <= mk[i] + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            logic       eb, es, ed;
            logic [7:0] edo;
            eb  = mbusy[i];
            es  = eb && !stall;
            ed  = es && (mk[i] == 32 / wid(i) - 1);
            edo = eb ? 8'((mres[i] >> (mk[i] * wid(i))) & ((32'h1 << wid(i)) - 1)) : 8'h00;
            chk($sformatf("model_w%0d", wid(i)),
                {busy[i], shift[i], done[i], 21'b0, dout_of(i)},
                {eb, es, ed, 21'b0, edo});
         end
         if (shift[act]) cap.push_back(dout_of(act));
         if (done[act]) begin
            done_cnt++;
            done_idx = cap.size() - 1;
         end
         if (busy[act]) busy_cyc++;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_cap(input int i);
      act      = i;
      cap.delete();
      done_cnt = 0;
      done_idx = -1;
      busy_cyc = 0;
   endtask

   task automatic go(input int i, input logic [31:0] b, input logic [31:0] o,
                     input logic a, input logic c);
      clr_cap(i);
      base     = b;
      off      = o;
      add      = a;
      clr      = c;
      start[i] = 1'b1;
      cyc();
      start[i] = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         cyc();
         n++;
      end
      chk("done_seen", done_cnt, 1);
      if (done_cnt != 0) cyc();
   endtask

   task automatic chk_seq(input string nm, input logic [7:0] e[$]);
      chk({nm, "_len"}, cap.size(), e.size());
      for (int j = 0; j < e.size() && j < cap.size(); j++)
         chk($sformatf("%s_c%0d", nm, j), {24'b0, cap[j]}, {24'b0, e[j]});
   endtask

   initial begin
      logic [7:0] e[$];
      logic [7:0] acc;
      rst   = 1'b1;
      start = '0;
      stall = 1'b0;
      add   = 1'b0;
      clr   = 1'b0;
      base  = '0;
      off   = '0;
      cyc();
      cyc();
      rst    = 1'b0;
      chk_en = 1'b1;
      chk("rst_outs", {29'b0, busy[0], shift[0], done[0]}, 32'd0);
      chk("rst_dout", {24'b0, d8}, 32'd0);

      // base only
      go(0, 32'h0000_1000, 32'h55, 1'b0, 1'b0);
      wait_done(20);
      e = '{8'h00, 8'h10, 8'h00, 8'h00};
      chk_seq("base_only", e);
      chk("base_only_done_idx", done_idx, 3);
      chk("base_only_lat", busy_cyc, 4);

      // carry across chunks; operands scrambled after acceptance
      go(0, 32'h0000_10FC, 32'h8, 1'b1, 1'b0);
      base = 32'hDEAD_BEEF;
      off  = 32'h1234_5678;
      clr  = 1'b1;
      wait_done(20);
      e = '{8'h04, 8'h11, 8'h00, 8'h00};
      chk_seq("carry", e);

      // 1-bit, carry out of bit 31 discarded
      go(1, 32'hFFFF_FFFC, 32'h4, 1'b1, 1'b0);
      wait_done(60);
      acc = '0;
      foreach (cap[j]) acc |= cap[j];
      chk("w1_len", cap.size(), 32);
      chk("w1_all_zero", {24'b0, acc}, 32'd0);
      chk("w1_done_idx", done_idx, 31);
      chk("w1_lat", busy_cyc, 32);

      // 4-bit with LSB clear
      go(2, 32'h101, 32'h2, 1'b1, 1'b1);
      wait_done(30);
      e = '{8'h2, 8'h0, 8'h1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
      chk_seq("clr_lsb", e);

      // two stall cycles during chunk 1
      go(0, 32'h0000_10FC, 32'h8, 1'b1, 1'b0);
      cyc();
      stall = 1'b1;
      @(negedge clk);
      chk("stall1_dout", {24'b0, d8}, 32'h11);
      chk("stall1_shift", {31'b0, shift[0]}, 32'd0);
      cyc();
      @(negedge clk);
      chk("stall2_dout", {24'b0, d8}, 32'h11);
      chk("stall2_shift", {31'b0, shift[0]}, 32'd0);
      cyc();
      stall = 1'b0;
      wait_done(20);
      e = '{8'h04, 8'h11, 8'h00, 8'h00};
      chk_seq("stall", e);
      chk("stall_lat", busy_cyc, 6);

      // reset in mid-run during chunk 2
      go(0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("abort_busy", {31'b0, busy[0]}, 32'd0);
      cyc();
      chk("abort_no_done", done_cnt, 0);

      // reset wins over start
      rst      = 1'b1;
      start[0] = 1'b1;
      cyc();
      rst      = 1'b0;
      start[0] = 1'b0;
      chk("rst_prio_busy", {31'b0, busy[0]}, 32'd0);

      // start during done cycle is ignored, start one cycle later is taken
      go(0, 32'h1111_1111, 32'h0, 1'b0, 1'b0);
      cyc();
      cyc();
      cyc();
      base     = 32'hAAAA_AAAA;
      start[0] = 1'b1;
      cyc();
      chk("done_start_ignored", {31'b0, busy[0]}, 32'd0);
      chk("first_done", done_cnt, 1);
      base = 32'h1234_5678;
      cyc();
      start[0] = 1'b0;
      chk("late_start_busy", {31'b0, busy[0]}, 32'd1);
      clr_cap(0);
      wait_done(20);
      e = '{8'h78, 8'h56, 8'h34, 8'h12};
      chk_seq("late_start", e);

      cyc();
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fazyrv_tgt_ser.md
FAZYRV_TGT_SER -- requirements
Module: fazyrv_tgt_ser

Interface
REQ-001 SHALL have parameter BWIDTH, default 8, meaning the serial chunk width in bits; legal values are 1, 2, 4 and 8.
REQ-002 SHALL have port clk_i  input  1  clock, rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port start_i  input  1  request to serialize a new target.
REQ-005 SHALL have port base_i  input  32  base operand (current PC or rs1).
REQ-006 SHALL have port off_i  input  32  offset operand (immediate).
REQ-007 SHALL have port add_i  input  1  1 = emit base_i+off_i; 0 = emit base_i.
REQ-008 SHALL have port clr_lsb_i  input  1  1 = force result bit 0 to 0 (JALR).
REQ-009 SHALL have port stall_i  input  1  holds the current chunk; no advance.
REQ-010 SHALL have port busy_o  output  1  high while in RUN.
REQ-011 SHALL have port shift_o  output  1  consumer shift strobe; feeds the PC shift input.
REQ-012 SHALL have port dout_o  output  BWIDTH  current result chunk, LSB chunk first; feeds the PC serial data input.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse coincident with the last chunk.

Function
REQ-014 SHALL implement states IDLE and RUN, with N = 32/BWIDTH chunks per transfer.
REQ-015 In IDLE, start_i=1 SHALL latch base_i, off_i (or zero when add_i=0) and clr_lsb_i, clear the carry register and chunk counter, and enter RUN on the next edge.
REQ-016 In RUN, dout_o SHALL equal chunk k of the result, bits [k*BWIDTH +: BWIDTH], for k = 0..N-1.
REQ-017 The result SHALL be the serial sum base+off mod 2^32, computed chunk by chunk with a 1-bit carry register; the carry out of bit 31 SHALL be discarded.
REQ-018 When clr_lsb_i was latched high, bit 0 of chunk 0 SHALL be 0; the carry into chunk 1 SHALL still come from the unmodified sum.
REQ-019 shift_o SHALL be high in RUN when stall_i=0, and low otherwise.
REQ-020 A chunk SHALL advance (counter+1, carry register updated) only when shift_o=1.
REQ-021 With stall_i=1, dout_o, the counter and the carry register SHALL hold.
REQ-022 done_o SHALL be high only when k = N-1 and shift_o=1; the next state SHALL then be IDLE.
REQ-023 Latency SHALL be exactly N cycles from entering RUN to IDLE when no stall occurs; each stall cycle SHALL add exactly one cycle.
REQ-024 start_i SHALL be ignored while in RUN, including the done cycle; a start asserted in the first IDLE cycle after done SHALL be accepted.
REQ-025 In IDLE, dout_o SHALL be 0 and shift_o, done_o and busy_o SHALL be 0.
REQ-026 busy_o SHALL equal (state == RUN).
REQ-027 Operand inputs SHALL be sampled only at start acceptance; later changes SHALL not affect the transfer in progress.

Reset
REQ-028 rst_i=1 at a clock edge SHALL force IDLE and clear the counter, the carry register and the operand registers.
REQ-029 After reset, busy_o, shift_o, done_o and dout_o SHALL all be 0.
REQ-030 Reset in mid-RUN SHALL abort the transfer with no done_o pulse.
REQ-031 rst_i SHALL take priority over start_i when both are asserted in the same cycle.

Verification
REQ-032 BWIDTH=8, base=0x0000_1000, add=0 -> chunks 0x00, 0x10, 0x00, 0x00 on 4 consecutive shift_o cycles, with done_o on the 4th.
REQ-033 BWIDTH=8, base=0x0000_10FC, off=0x8, add=1 -> 0x0000_1104, emitted as chunks 0x04, 0x11, 0x00, 0x00 (carry propagated across chunks).
REQ-034 BWIDTH=1, base=0xFFFF_FFFC, off=0x4, add=1 -> 32 zero bits, carry discarded, done_o on the 32nd bit.
REQ-035 BWIDTH=4, base=0x101, off=0x2, add=1, clr_lsb=1 -> 0x102, emitted as chunks 2, 0, 1, 0, 0, 0, 0, 0.
REQ-036 BWIDTH=8, stall_i high for 2 cycles during chunk 1 -> dout_o holds 0x11, shift_o=0, and total latency is 6 cycles.
REQ-037 BWIDTH=8, rst_i during chunk 2, and start_i asserted in the done cycle -> after rst_i: IDLE with no done_o; in the done cycle: start ignored, and a start one cycle later is accepted.
